// File: rtl/rng_draw.sv
`default_nettype none
// ============================================================================
// Module   : rng_draw
// Purpose  : Request/valid pseudo-random draw engine. A Fibonacci LFSR is
//            stirred STEPS times per draw, then the sample is reduced by an
//            exact MSB-first restoring modulo into [OFFSET, OFFSET+RANGE-1].
// Revision : 1.0 - initial release
// ============================================================================
module rng_draw #(
  parameter int          WIDTH     = 18,
  parameter logic [31:0] TAPS      = 32'h0002_0400,
  parameter int          SEED      = 2468,
  parameter int          STEPS     = 8,
  parameter int          RANGE     = 18,
  parameter int          OFFSET    = 1,
  parameter int          OUT_WIDTH = 18
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 free_run,
  input  logic                 seed_load,
  input  logic [WIDTH-1:0]     seed_in,
  input  logic                 req,
  output logic                 busy,
  output logic                 valid,
  output logic [OUT_WIDTH-1:0] value,
  output logic [WIDTH-1:0]     lfsr_state
);

  // Remainder is always < RANGE, so clog2(RANGE)+1 bits never overflow.
  localparam int REM_W = $clog2(RANGE) + 1;
  localparam int IDX_W = $clog2(WIDTH);
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

  localparam logic [WIDTH-1:0]     TAP_MASK  = TAPS[WIDTH-1:0];
  localparam logic [WIDTH-1:0]     SEED_T    = SEED[WIDTH-1:0];
  // A zero LFSR would lock up, so a zero seed falls back to 1.
  localparam logic [WIDTH-1:0]     SEED_SAFE = (SEED_T == '0) ? WIDTH'(1) : SEED_T;
  localparam logic [CNT_W-1:0]     STEP_LAST = CNT_W'(STEPS - 1);
  localparam logic [IDX_W-1:0]     IDX_LAST  = IDX_W'(WIDTH - 1);
  localparam logic [REM_W:0]       RANGE_R   = (REM_W + 1)'(RANGE);
  localparam logic [OUT_WIDTH-1:0] OFFSET_V  = OUT_WIDTH'(OFFSET);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STIR   = 2'd1,
    S_REDUCE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t                 state_q;
  logic [WIDTH-1:0]       lfsr_q;
  logic [WIDTH-1:0]       sample_q;
  logic [REM_W-1:0]       rem_q;
  logic [IDX_W-1:0]       idx_q;
  logic [CNT_W-1:0]       step_q;
  logic [OUT_WIDTH-1:0]   value_q;
  logic                   valid_q;
  logic                   busy_q;

  logic [WIDTH-1:0]       lfsr_step_d;
  logic [WIDTH-1:0]       seed_safe_d;
  logic [REM_W:0]         trial_d;
  logic [REM_W-1:0]       rem_d;
  logic [OUT_WIDTH-1:0]   value_d;

  // Next LFSR value, guarded seed, and one restoring-modulo step.
  always_comb begin
    lfsr_step_d = {lfsr_q[WIDTH-2:0], ^(lfsr_q & TAP_MASK)};
    seed_safe_d = (seed_in == '0) ? SEED_SAFE : seed_in;
    trial_d     = {rem_q, sample_q[IDX_LAST - idx_q]};
    rem_d       = (trial_d >= RANGE_R) ? REM_W'(trial_d - RANGE_R) : trial_d[REM_W-1:0];
    value_d     = OUT_WIDTH'(rem_d) + OFFSET_V;
  end

  // Draw controller: seeding/free-run in IDLE, stir, reduce, publish result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      lfsr_q   <= SEED_SAFE;
      sample_q <= '0;
      rem_q    <= '0;
      idx_q    <= '0;
      step_q   <= '0;
      value_q  <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (seed_load) begin
            lfsr_q <= seed_safe_d;
          end else if (req) begin
            lfsr_q  <= lfsr_step_d;
            step_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= S_STIR;
          end else if (free_run) begin
            lfsr_q <= lfsr_step_d;
          end
        end
        S_STIR: begin
          // The accept cycle already made the first shift; the final STIR
          // cycle only captures the sample.
          if (step_q == STEP_LAST) begin
            sample_q <= lfsr_q;
            rem_q    <= '0;
            idx_q    <= '0;
            state_q  <= S_REDUCE;
          end else begin
            lfsr_q <= lfsr_step_d;
            step_q <= step_q + CNT_W'(1);
          end
        end
        S_REDUCE: begin
          rem_q <= rem_d;
          if (idx_q == IDX_LAST) begin
            value_q <= value_d;
            valid_q <= 1'b1;
            state_q <= S_DONE;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign valid      = valid_q;
  assign value      = value_q;
  assign lfsr_state = lfsr_q;

endmodule
`default_nettype wire
